// File: rtl/rej_poly_writer_if.sv
// rej_poly_writer_if
//   Bundles the control, sampler-beat and memory-write signals of
//   rej_poly_writer. clk and rst stay as plain module ports.
//   Modports:
//     master : the sampler/controller side; drives zeroize, start_i,
//              dest_base_addr_i, data_valid_i and data_i, and observes the
//              memory write port and the status flags.
//     slave  : the writer itself; receives the inputs above and drives
//              mem_we_o, mem_addr_o, mem_wdata_o, busy_o, stop_o, done_o
//              and error_o.
interface rej_poly_writer_if #(
  parameter int MEM_ADDR_W   = 15,
  parameter int COEFF_PER_WR = 4,
  parameter int COEFF_W      = 24
);
  logic                              zeroize;
  logic                              start_i;
  logic [MEM_ADDR_W-1:0]             dest_base_addr_i;
  logic                              data_valid_i;
  logic [COEFF_PER_WR*COEFF_W-1:0]   data_i;

  logic                              mem_we_o;
  logic [MEM_ADDR_W-1:0]             mem_addr_o;
  logic [COEFF_PER_WR*COEFF_W-1:0]   mem_wdata_o;
  logic                              busy_o;
  logic                              stop_o;
  logic                              done_o;
  logic                              error_o;

  modport master (
    output zeroize, start_i, dest_base_addr_i, data_valid_i, data_i,
    input  mem_we_o, mem_addr_o, mem_wdata_o, busy_o, stop_o, done_o, error_o
  );

  modport slave (
    input  zeroize, start_i, dest_base_addr_i, data_valid_i, data_i,
    output mem_we_o, mem_addr_o, mem_wdata_o, busy_o, stop_o, done_o, error_o
  );
endinterface

// File: rtl/rej_poly_writer.sv
// rej_poly_writer
//   Packs accepted coefficient beats from the rejection sampler into memory
//   words and writes one full polynomial starting at a latched base address.
//   Flags done on the final write, asks upstream to stop, and keeps a sticky
//   out-of-range error.
//   Ports:
//     clk  - clock
//     rst  - asynchronous active-high reset
//     bus  - rej_poly_writer_if.slave: control (zeroize, start_i,
//            dest_base_addr_i), sampler beat (data_valid_i, data_i),
//            memory write (mem_we_o, mem_addr_o, mem_wdata_o) and status
//            (busy_o, stop_o, done_o, error_o).
module rej_poly_writer #(
  parameter int NUM_COEFF    = 256,
  parameter int COEFF_PER_WR = 4,
  parameter int COEFF_W      = 24,
  parameter int REJ_VALUE    = 8380417,
  parameter int MEM_ADDR_W   = 15,
  parameter int WR_CNT_W     = $clog2(NUM_COEFF / COEFF_PER_WR)
) (
  input  logic             clk,
  input  logic             rst,
  rej_poly_writer_if.slave bus
);

  localparam logic [WR_CNT_W-1:0] LAST_CNT  = WR_CNT_W'(NUM_COEFF / COEFF_PER_WR - 1);
  localparam logic [COEFF_W-1:0]  REJ_LIMIT = COEFF_W'(REJ_VALUE);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                            state_reg, state_next;
  logic [WR_CNT_W-1:0]               cnt_reg;
  logic [MEM_ADDR_W-1:0]             base_reg;
  logic                              we_reg;
  logic [MEM_ADDR_W-1:0]             addr_reg;
  logic [COEFF_PER_WR*COEFF_W-1:0]   wdata_reg;
  logic                              error_reg;

  logic                              accept;
  logic                              last_beat;
  logic                              busy_next;
  logic                              stop_next;
  logic                              done_next;
  logic [COEFF_PER_WR-1:0]           lane_bad;

  // Per-lane range check of the incoming beat.
  generate
    for (genvar gi = 0; gi < COEFF_PER_WR; gi++) begin : g_lane_chk
      assign lane_bad[gi] = (bus.data_i[gi*COEFF_W +: COEFF_W] >= REJ_LIMIT);
    end
  endgenerate

  // Beats are only taken while ACTIVE; IDLE and DONE silently drop them.
  assign accept    = (state_reg == ACTIVE) && bus.data_valid_i;
  assign last_beat = accept && (cnt_reg == LAST_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else if (bus.zeroize) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    busy_next  = 1'b0;
    stop_next  = 1'b0;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start_i) state_next = ACTIVE;
      end
      ACTIVE: begin
        busy_next = 1'b1;
        // Combinational stop on the final beat so upstream halts at once.
        if (last_beat) begin
          stop_next  = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        // The final write lands in this cycle, so done coincides with it.
        stop_next  = 1'b1;
        done_next  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg   <= '0;
      base_reg  <= '0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      error_reg <= 1'b0;
    end else if (bus.zeroize) begin
      cnt_reg   <= '0;
      base_reg  <= '0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      error_reg <= 1'b0;
    end else begin
      we_reg <= accept;
      if ((state_reg == IDLE) && bus.start_i) begin
        base_reg  <= bus.dest_base_addr_i;
        cnt_reg   <= '0;
        error_reg <= 1'b0;
      end
      if (accept) begin
        // Address wraps modulo 2^MEM_ADDR_W by plain truncation.
        addr_reg  <= base_reg + MEM_ADDR_W'(cnt_reg);
        wdata_reg <= bus.data_i;
        cnt_reg   <= last_beat ? '0 : cnt_reg + 1'b1;
        // The bad word is still written; only the flag records it.
        if (|lane_bad) error_reg <= 1'b1;
      end
    end
  end

  assign bus.mem_we_o    = we_reg;
  assign bus.mem_addr_o  = addr_reg;
  assign bus.mem_wdata_o = wdata_reg;
  assign bus.busy_o      = busy_next;
  assign bus.stop_o      = stop_next;
  assign bus.done_o      = done_next;
  assign bus.error_o     = error_reg;

endmodule

// File: tb/tb_rej_poly_writer.sv
// tb_rej_poly_writer
//   Directed bench for rej_poly_writer: basic run, gapped input, address
//   wrap, range error, zeroize abort, asynchronous reset abort and the stop
//   handshake. Expected values come from the beat index and base address.
module tb_rej_poly_writer;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  rej_poly_writer_if #(.MEM_ADDR_W(15), .COEFF_PER_WR(4), .COEFF_W(24)) bus ();

  rej_poly_writer #(
    .NUM_COEFF(256), .COEFF_PER_WR(4), .COEFF_W(24),
    .REJ_VALUE(8380417), .MEM_ADDR_W(15)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Lanes hold 4k..4k+3; optional out-of-range or just-in-range lane.
  function automatic logic [95:0] mk(input int k, input int bad_beat, input int edge_beat);
    logic [23:0] l0, l1, l2, l3;
    l0 = 24'(4*k);
    l1 = 24'(4*k + 1);
    l2 = 24'(4*k + 2);
    l3 = 24'(4*k + 3);
    if (k == bad_beat)  l2 = 24'd8380417;
    if (k == edge_beat) l3 = 24'd8380416;
    return {l3, l2, l1, l0};
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, ".we"},    bus.mem_we_o,    '0);
    check({tag, ".addr"},  bus.mem_addr_o,  '0);
    check({tag, ".wdata"}, bus.mem_wdata_o, '0);
    check({tag, ".busy"},  bus.busy_o,      '0);
    check({tag, ".stop"},  bus.stop_o,      '0);
    check({tag, ".done"},  bus.done_o,      '0);
    check({tag, ".err"},   bus.error_o,     '0);
  endtask

  // Starts a polynomial and feeds n_beats accepted beats, checking every cycle.
  task automatic run_poly(input string tag, input logic [14:0] base, input bit gapped,
                          input int bad_beat, input int edge_beat, input int n_beats,
                          input bit start_mid);
    int          k;
    int          cyc;
    logic        v;
    logic        err_exp;
    logic        fin;
    logic [95:0] d;
    logic [95:0] last_d;
    logic [14:0] exp_addr;
    logic [14:0] last_addr;
    bus.dest_base_addr_i = base;
    bus.start_i          = 1'b1;
    tick();
    bus.start_i = 1'b0;
    check({tag, ".start_busy"}, bus.busy_o,  1'b1);
    check({tag, ".start_err"},  bus.error_o, 1'b0);
    k = 0; cyc = 0; err_exp = 1'b0; last_d = '0; last_addr = '0;
    while (k < n_beats && cyc < 2000) begin
      v = gapped ? (((cyc * 7) % 10) < 3) : 1'b1;
      d = v ? mk(k, bad_beat, edge_beat) : {96{1'b1}};
      bus.data_valid_i = v;
      bus.data_i       = d;
      if (start_mid && k == 30) begin
        bus.start_i          = 1'b1;
        bus.dest_base_addr_i = 15'h555;
      end
      fin = v && (k == 63);
      #1;
      check({tag, ".stop_comb"}, bus.stop_o, fin);
      tick();
      bus.start_i          = 1'b0;
      bus.dest_base_addr_i = base;
      check({tag, ".we"}, bus.mem_we_o, v);
      if (v) begin
        exp_addr = base + 15'(k);
        check({tag, ".addr"},  bus.mem_addr_o,  exp_addr);
        check({tag, ".wdata"}, bus.mem_wdata_o, d);
        last_d    = d;
        last_addr = exp_addr;
        if (k == bad_beat) err_exp = 1'b1;
        k++;
      end
      check({tag, ".err"},  bus.error_o, err_exp);
      check({tag, ".done"}, bus.done_o,  fin);
      check({tag, ".busy"}, bus.busy_o,  !fin);
      cyc++;
    end
    bus.data_valid_i = 1'b0;
    check({tag, ".timeout"}, (cyc < 2000), 1'b1);
    if (n_beats == 64) begin
      // DONE cycle: a valid beat here must be dropped (all-ones would flag error).
      bus.data_valid_i = 1'b1;
      bus.data_i       = {96{1'b1}};
      #1;
      check({tag, ".stop_done"}, bus.stop_o, 1'b1);
      tick();
      check({tag, ".post_we"},    bus.mem_we_o,    1'b0);
      check({tag, ".post_done"},  bus.done_o,      1'b0);
      check({tag, ".post_busy"},  bus.busy_o,      1'b0);
      check({tag, ".post_err"},   bus.error_o,     err_exp);
      check({tag, ".hold_addr"},  bus.mem_addr_o,  last_addr);
      check({tag, ".hold_wdata"}, bus.mem_wdata_o, last_d);
      #1;
      check({tag, ".post_stop"}, bus.stop_o, 1'b0);
      bus.data_valid_i = 1'b0;
      tick();
      check({tag, ".idle_we"}, bus.mem_we_o, 1'b0);
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst                  = 1'b0;
    bus.zeroize          = 1'b0;
    bus.start_i          = 1'b0;
    bus.dest_base_addr_i = '0;
    bus.data_valid_i     = 1'b0;
    bus.data_i           = '0;
    #1 rst = 1'b1;
    #1;
    check_all_zero("reset");
    tick();
    tick();
    rst = 1'b0;
    tick();
    check_all_zero("after_reset");

    // Valid while IDLE must not write.
    bus.data_valid_i = 1'b1;
    bus.data_i       = mk(5, -1, -1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_valid.we",   bus.mem_we_o, 1'b0);
      check("idle_valid.busy", bus.busy_o,   1'b0);
    end
    bus.data_valid_i = 1'b0;

    run_poly("basic",  15'h0100, 1'b0, -1, -1, 64, 1'b1);
    run_poly("gapped", 15'h0040, 1'b1, -1, -1, 64, 1'b0);
    run_poly("wrap",   15'h7FF0, 1'b0, -1,  5, 64, 1'b0);
    run_poly("range",  15'h0300, 1'b0, 10, -1, 64, 1'b0);
    check("range.err_sticky", bus.error_o, 1'b1);

    // Start clears the error; error is set again at beat 3, then zeroize aborts.
    run_poly("abort", 15'h0200, 1'b0, 3, -1, 20, 1'b0);
    check("abort.err_before", bus.error_o, 1'b1);
    bus.zeroize      = 1'b1;
    bus.start_i      = 1'b1;
    bus.data_valid_i = 1'b1;
    bus.data_i       = mk(20, -1, -1);
    tick();
    check_all_zero("zeroize");
    bus.zeroize = 1'b0;
    bus.start_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("zeroize_after.we",   bus.mem_we_o, 1'b0);
      check("zeroize_after.done", bus.done_o,   1'b0);
      check("zeroize_after.busy", bus.busy_o,   1'b0);
    end
    bus.data_valid_i = 1'b0;

    // Asynchronous reset between clock edges.
    run_poly("async", 15'h0400, 1'b0, -1, -1, 10, 1'b0);
    check("async.we_before", bus.mem_we_o, 1'b1);
    bus.data_valid_i = 1'b1;
    bus.data_i       = mk(10, -1, -1);
    #2 rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    #1 rst = 1'b0;
    tick();
    check("async_after.we",   bus.mem_we_o, 1'b0);
    check("async_after.busy", bus.busy_o,   1'b0);
    check("async_after.done", bus.done_o,   1'b0);
    bus.data_valid_i = 1'b0;

    run_poly("recover", 15'h0010, 1'b0, -1, -1, 64, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
